mdio_master: RTL

MDIO_MASTER -- requirements
Module: mdio_master

---
 rtl/mdio_pkg.sv | 16 +
 rtl/mdc_gen.sv | 33 +++
 rtl/mdio_master.sv | 109 ++++++++++
 3 files changed

// File: rtl/mdio_pkg.sv
// mdio_pkg: shared MDIO frame constants, FSM state encoding and frame builder
package mdio_pkg;
    localparam logic [1:0] ST       = 2'b01;
    localparam logic [1:0] OP_WR    = 2'b01;
    localparam logic [1:0] OP_RD    = 2'b10;
    localparam logic [1:0] TA_WRITE = 2'b10;
    localparam int         HDR_BITS  = 14;
    localparam int         TA_BITS   = 2;
    localparam int         DATA_BITS = 16;
    typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_TA, S_DATA} state_t;
    // Everything after the preamble, MSB first: ST, OP, PHYAD, REGAD, TA, DATA
    function automatic logic [31:0] frame_word(input logic [1:0] op, input logic [4:0] phy,
                                               input logic [4:0] rga, input logic [15:0] data);
        return {ST, op, phy, rga, TA_WRITE, data};
    endfunction
endpackage

// File: rtl/mdc_gen.sv
// mdc_gen: divides clk into mdc with one-cycle strobes ahead of each mdc edge
// clk, rst_n : clock, async active-low reset
// en         : run the divider; when low mdc is held low and the counter cleared
// mdc        : management clock, low for CLK_DIV cycles then high for CLK_DIV cycles
// rise_stb   : high in the cycle before mdc rises
// fall_stb   : high in the cycle before mdc falls
module mdc_gen #(
    parameter int CLK_DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic mdc,
    output logic rise_stb,
    output logic fall_stb
);
    logic [7:0] cnt;
    logic       wrap;
    assign wrap     = en && cnt == 8'(CLK_DIV - 1);
    assign rise_stb = wrap && !mdc;
    assign fall_stb = wrap && mdc;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            mdc <= 1'b0;
        end else if (!en || wrap) begin
            cnt <= '0;
            mdc <= en && !mdc;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end
endmodule

// File: rtl/mdio_master.sv
// mdio_master: IEEE 802.3 clause 22 MDIO management master (one frame at a time)
// clk, rst_n        : clock, async-assert / sync-release active-low reset
// phy_add, reg_add  : request addresses; wr_data : write payload
// wren, rden        : request strobes (write wins), ignored while busy
// busy              : frame in progress
// rd_data, rd_valid, rd_err : read result, completion pulse, no-ack flag
// mdc, mdio_o, mdio_oe, mdio_i : management clock and data pad signals
module mdio_master
    import mdio_pkg::*;
#(
    parameter int CLK_DIV      = 10,
    parameter int PREAMBLE_LEN = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  phy_add,
    input  logic [4:0]  reg_add,
    input  logic [15:0] wr_data,
    input  logic        wren,
    input  logic        rden,
    output logic        busy,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        rd_err,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i
);
    logic [1:0]  rst_sr;
    logic        rst_i;
    state_t      state, state_d;
    logic [5:0]  bit_cnt, cnt_d, len;
    logic [31:0] sr, sr_d;
    logic [15:0] rd_sr;
    logic        is_rd, rd_d, ta_q, last, o_d, oe_d, rd_valid_d, rise_stb, fall_stb;
    // Reset asserts immediately but releases only after two clean clk edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sr <= 2'b00;
        else        rst_sr <= {rst_sr[0], 1'b1};
    end
    assign rst_i = rst_sr[1];
    assign busy  = state != S_IDLE;
    mdc_gen #(.CLK_DIV(CLK_DIV)) u_mdc (
        .clk      (clk),
        .rst_n    (rst_i),
        .en       (busy),
        .mdc      (mdc),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );
    always_comb begin
        state_d    = state;
        cnt_d      = bit_cnt;
        sr_d       = sr;
        rd_d       = is_rd;
        rd_valid_d = 1'b0;
        len  = state == S_PRE ? 6'(PREAMBLE_LEN) : state == S_HDR ? 6'(HDR_BITS) :
               state == S_TA  ? 6'(TA_BITS)      : 6'(DATA_BITS);
        last = bit_cnt == len - 6'd1;
        if (state == S_IDLE) begin
            if (wren || rden) begin
                state_d = PREAMBLE_LEN == 0 ? S_HDR : S_PRE;
                cnt_d   = '0;
                rd_d    = !wren;
                sr_d    = frame_word(wren ? OP_WR : OP_RD, phy_add, reg_add, wr_data);
            end
        end else if (fall_stb) begin
            state_d    = !last ? state : state == S_DATA ? S_IDLE : state_t'(state + 3'd1);
            cnt_d      = last ? '0 : bit_cnt + 6'd1;
            // The preamble is generated, not shifted, so sr[31] stays on ST until HDR
            sr_d       = state == S_PRE ? sr : sr << 1;
            rd_valid_d = last && state == S_DATA && is_rd;
        end
        // state_d/sr_d only move at acceptance or mdc falling, so the pad follows suit
        o_d  = state_d == S_IDLE || state_d == S_PRE || sr_d[31];
        oe_d = state_d != S_IDLE && !(rd_d && (state_d == S_TA || state_d == S_DATA));
    end
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            state    <= S_IDLE;
            bit_cnt  <= '0;
            sr       <= '0;
            is_rd    <= 1'b0;
            ta_q     <= 1'b0;
            rd_sr    <= '0;
            mdio_o   <= 1'b1;
            mdio_oe  <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
        end else begin
            state    <= state_d;
            bit_cnt  <= cnt_d;
            sr       <= sr_d;
            is_rd    <= rd_d;
            mdio_o   <= o_d;
            mdio_oe  <= oe_d;
            rd_valid <= rd_valid_d;
            if (rise_stb && state == S_TA && bit_cnt == 6'd1) ta_q <= mdio_i;
            if (rise_stb && state == S_DATA) rd_sr <= {rd_sr[14:0], mdio_i};
            // Result registers only move at completion so the last read stays visible
            if (rd_valid_d) begin
                rd_data <= rd_sr;
                rd_err  <= ta_q;
            end
        end
    end
endmodule
